// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch requester and
//   the data (lw/sw) requester of a 5-stage pipeline. Data has fixed priority,
//   bounded by a streak limit so a waiting fetch cannot starve. Each memory
//   transaction runs IDLE -> BUSY (wait states until MemAck or timeout) -> RESP
//   (one-cycle Valid pulse to the owner).
//
// Ports
//   Clk, Rst_n                 clock (rising edge), async active-low reset
//   IfReq/IfAddr               fetch request, held until IfValid
//   IfRdata/IfValid/IfStall    fetch response, completion pulse, stall
//   DReq/DWe/DAddr/DWdata      data request (DWe=1 store), held until DValid
//   DRdata/DValid/DStall       load data, completion pulse, stall
//   MemReq/MemWe/MemAddr/MemWdata  registered memory command
//   MemRdata/MemAck            memory read data and completion
//   Err                        sticky timeout flag
module mem_port_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        IfReq,
    input  logic [31:0] IfAddr,
    output logic [31:0] IfRdata,
    output logic        IfValid,
    output logic        IfStall,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWdata,
    output logic [31:0] DRdata,
    output logic        DValid,
    output logic        DStall,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWdata,
    input  logic [31:0] MemRdata,
    input  logic        MemAck,
    output logic        Err
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic          owner_d_q, owner_d_d;   // 1 = data requester owns the transaction
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          err_q, err_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [WW-1:0] wait_q, wait_d;

    logic grant_d, grant_i;

    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        err_d       = err_q;
        streak_d    = streak_q;
        wait_d      = wait_q;
        // Data wins unless it has already taken MAX_DSTREAK grants in a row
        // while the fetch was waiting.
        grant_d     = DReq & (~IfReq | (streak_q < SW'(MAX_DSTREAK)));
        grant_i     = IfReq & ~grant_d;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = BUSY;
                    owner_d_d   = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = DWe;
                    mem_addr_d  = DAddr;
                    mem_wdata_d = DWdata;
                    wait_d      = '0;
                    if (!IfReq)
                        streak_d = '0;
                    else if (streak_q != SW'(MAX_DSTREAK))
                        streak_d = streak_q + SW'(1);
                end else if (grant_i) begin
                    state_d     = BUSY;
                    owner_d_d   = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = IfAddr;
                    mem_wdata_d = '0;
                    wait_d      = '0;
                    streak_d    = '0;
                end
            end
            BUSY: begin
                wait_d = wait_q + WW'(1);
                if (MemAck || wait_q == WW'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (owner_d_q) d_valid_d  = 1'b1;
                    else           if_valid_d = 1'b1;
                    if (MemAck) begin
                        // Stores return nothing; DRdata keeps the last load.
                        if (!owner_d_q)     if_rdata_d = MemRdata;
                        else if (!mem_we_q) d_rdata_d  = MemRdata;
                    end else begin
                        err_d = 1'b1;
                        if (owner_d_q) d_rdata_d  = '0;
                        else           if_rdata_d = '0;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            streak_q    <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_d_q   <= owner_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            err_q       <= err_d;
            streak_q    <= streak_d;
            wait_q      <= wait_d;
        end
    end

    assign IfRdata  = if_rdata_q;
    assign IfValid  = if_valid_q;
    assign IfStall  = IfReq & ~if_valid_q;
    assign DRdata   = d_rdata_q;
    assign DValid   = d_valid_q;
    assign DStall   = DReq & ~d_valid_q;
    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWdata = mem_wdata_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a per-cycle vector table for load/store/withdraw
// flows, then hand-written sequences for starvation, timeout and mid-op reset.
module tb_mem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        IfReq = 1'b0;
    logic [31:0] IfAddr = '0;
    logic [31:0] IfRdata;
    logic        IfValid, IfStall;
    logic        DReq = 1'b0;
    logic        DWe = 1'b0;
    logic [31:0] DAddr = '0;
    logic [31:0] DWdata = '0;
    logic [31:0] DRdata;
    logic        DValid, DStall;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWdata;
    logic [31:0] MemRdata = '0;
    logic        MemAck = 1'b0;
    logic        Err;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .IfReq(IfReq), .IfAddr(IfAddr), .IfRdata(IfRdata), .IfValid(IfValid), .IfStall(IfStall),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
        .DRdata(DRdata), .DValid(DValid), .DStall(DStall),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemRdata(MemRdata), .MemAck(MemAck), .Err(Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_ifv;
        logic        e_dv;
        logic        e_ifs;
        logic        e_ds;
        logic [31:0] e_ifr;
        logic [31:0] e_dr;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] dwd, input logic ak, input logic [31:0] rd,
        input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] mwd,
        input logic ifv, input logic dv, input logic ifs, input logic ds,
        input logic [31:0] ifr, input logic [31:0] drd, input logic er);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
        v.d_wdata = dwd; v.ack = ak; v.rdata = rd;
        v.e_mreq = mr; v.e_mwe = mw; v.e_maddr = ma; v.e_mwdata = mwd;
        v.e_ifv = ifv; v.e_dv = dv; v.e_ifs = ifs; v.e_ds = ds;
        v.e_ifr = ifr; v.e_dr = drd; v.e_err = er;
        return v;
    endfunction

    initial begin : main
        logic [9:0] order;
        int         gi, ifv_cnt, both_cnt, busy_cnt, dv_in_rst;
        bit         done;

        //             if ifaddr  d we daddr  dwdata       ack rdata          mreq we maddr  mwdata       ifv dv ifs ds ifrdata      drdata       err
        // single load, immediate ack
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h40, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h40, 32'h0,        1, 32'h12345678, 1, 0, 32'h40,  32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h40, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 1, 0, 0, 32'h0,        32'h12345678, 0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,        32'h12345678, 0));
        // store with three memory cycles; ack data must not reach DRdata
        vecs.push_back(mk(0, 32'h0,   1, 1, 32'h80, 32'hDEADBEEF, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 0, 1, 32'h0,        32'h12345678, 0));
        vecs.push_back(mk(0, 32'h0,   1, 1, 32'h80, 32'hDEADBEEF, 0, 32'h0,        1, 1, 32'h80,  32'hDEADBEEF, 0, 0, 0, 1, 32'h0,        32'h12345678, 0));
        vecs.push_back(mk(0, 32'h0,   1, 1, 32'h80, 32'hDEADBEEF, 0, 32'h0,        1, 1, 32'h80,  32'hDEADBEEF, 0, 0, 0, 1, 32'h0,        32'h12345678, 0));
        vecs.push_back(mk(0, 32'h0,   1, 1, 32'h80, 32'hDEADBEEF, 1, 32'hCAFEF00D, 1, 1, 32'h80,  32'hDEADBEEF, 0, 0, 0, 1, 32'h0,        32'h12345678, 0));
        vecs.push_back(mk(0, 32'h0,   1, 1, 32'h80, 32'hDEADBEEF, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 1, 0, 0, 32'h0,        32'h12345678, 0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,        32'h12345678, 0));
        // fetch withdrawn after grant still completes
        vecs.push_back(mk(1, 32'h100, 0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 1, 0, 32'h0,        32'h12345678, 0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 32'h0,  32'h0,        0, 32'h0,        1, 0, 32'h100, 32'h0,        0, 0, 1, 0, 32'h0,        32'h12345678, 0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,  32'h0,        1, 32'h0BADC0DE, 1, 0, 32'h100, 32'h0,        0, 0, 0, 0, 32'h0,        32'h12345678, 0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        1, 0, 0, 0, 32'h0BADC0DE, 32'h12345678, 0));
        // stray ack while idle does nothing
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,  32'h0,        1, 32'hFFFFFFFF, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0BADC0DE, 32'h12345678, 0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0BADC0DE, 32'h12345678, 0));

        // asynchronous reset clears outputs with no clock edge
        #1 Rst_n = 1'b0;
        #1;
        chk("rst MemReq", {31'b0, MemReq}, 32'h0);
        chk("rst MemAddr", MemAddr, 32'h0);
        chk("rst MemWdata", MemWdata, 32'h0);
        chk("rst valids", {30'b0, IfValid, DValid}, 32'h0);
        chk("rst rdata", IfRdata | DRdata, 32'h0);
        chk("rst Err", {31'b0, Err}, 32'h0);
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge Clk);
            #1;
            IfReq = vecs[i].if_req; IfAddr = vecs[i].if_addr;
            DReq = vecs[i].d_req; DWe = vecs[i].d_we; DAddr = vecs[i].d_addr; DWdata = vecs[i].d_wdata;
            MemAck = vecs[i].ack; MemRdata = vecs[i].rdata;
            @(negedge Clk);
            chk($sformatf("v%0d MemReq", i), {31'b0, MemReq}, {31'b0, vecs[i].e_mreq});
            if (vecs[i].e_mreq) begin
                chk($sformatf("v%0d MemWe", i), {31'b0, MemWe}, {31'b0, vecs[i].e_mwe});
                chk($sformatf("v%0d MemAddr", i), MemAddr, vecs[i].e_maddr);
                if (vecs[i].e_mwe)
                    chk($sformatf("v%0d MemWdata", i), MemWdata, vecs[i].e_mwdata);
            end
            chk($sformatf("v%0d IfValid", i), {31'b0, IfValid}, {31'b0, vecs[i].e_ifv});
            chk($sformatf("v%0d DValid", i), {31'b0, DValid}, {31'b0, vecs[i].e_dv});
            chk($sformatf("v%0d IfStall", i), {31'b0, IfStall}, {31'b0, vecs[i].e_ifs});
            chk($sformatf("v%0d DStall", i), {31'b0, DStall}, {31'b0, vecs[i].e_ds});
            chk($sformatf("v%0d IfRdata", i), IfRdata, vecs[i].e_ifr);
            chk($sformatf("v%0d DRdata", i), DRdata, vecs[i].e_dr);
            chk($sformatf("v%0d Err", i), {31'b0, Err}, {31'b0, vecs[i].e_err});
        end

        // starvation: both held, immediate acks -> D,D,D,D,I,D,D,D,D,I
        @(posedge Clk);
        #1;
        IfReq = 1'b1; IfAddr = 32'h200;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h300;
        MemAck = 1'b1; MemRdata = 32'h11111111;
        order = '0; gi = 0; ifv_cnt = 0; both_cnt = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge Clk);
            if (MemReq && gi < 10) begin
                order[gi] = (MemAddr == 32'h300);
                gi++;
            end
            if (IfValid) ifv_cnt++;
            if (IfValid && DValid) both_cnt++;
            if (gi == 10 && (IfValid || DValid)) done = 1'b1;
        end
        IfReq = 1'b0; DReq = 1'b0; MemAck = 1'b0;
        chk("starve grants", gi, 10);
        chk("starve order", {22'b0, order}, {22'b0, 10'b0111101111});
        chk("starve ifvalid count", ifv_cnt, 2);
        chk("starve both valid", both_cnt, 0);

        // timeout on a fetch: 15 BUSY cycles, zero data, sticky Err
        @(posedge Clk);
        #1;
        IfReq = 1'b1; IfAddr = 32'h400;
        busy_cnt = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge Clk);
            if (MemReq) busy_cnt++;
            else if (busy_cnt > 0) done = 1'b1;
        end
        chk("timeout busy cycles", busy_cnt, 15);
        chk("timeout IfValid", {31'b0, IfValid}, 32'h1);
        chk("timeout IfRdata", IfRdata, 32'h0);
        chk("timeout Err", {31'b0, Err}, 32'h1);
        IfReq = 1'b0;

        // later successful load keeps Err set
        @(posedge Clk);
        #1;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h600; MemAck = 1'b1; MemRdata = 32'h00000077;
        repeat (3) @(negedge Clk);
        chk("post-timeout DValid", {31'b0, DValid}, 32'h1);
        chk("post-timeout DRdata", DRdata, 32'h77);
        chk("post-timeout Err", {31'b0, Err}, 32'h1);
        DReq = 1'b0; MemAck = 1'b0;

        // reset in the second BUSY cycle of a load
        @(posedge Clk);
        #1;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h500; MemAck = 1'b0;
        repeat (2) @(negedge Clk);
        chk("midrst busy1 MemReq", {31'b0, MemReq}, 32'h1);
        @(negedge Clk);
        chk("midrst busy2 MemReq", {31'b0, MemReq}, 32'h1);
        #1 Rst_n = 1'b0;
        #1;
        chk("midrst MemReq", {31'b0, MemReq}, 32'h0);
        chk("midrst DValid", {31'b0, DValid}, 32'h0);
        chk("midrst Err", {31'b0, Err}, 32'h0);
        dv_in_rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (DValid || MemReq) dv_in_rst++;
        end
        Rst_n = 1'b1;
        @(negedge Clk);
        if (DValid) dv_in_rst++;
        chk("midrst no pulse", dv_in_rst, 0);
        chk("restart MemReq", {31'b0, MemReq}, 32'h1);
        chk("restart MemAddr", MemAddr, 32'h500);
        MemAck = 1'b1; MemRdata = 32'h55AA55AA;
        @(negedge Clk);
        chk("restart DValid", {31'b0, DValid}, 32'h1);
        chk("restart DRdata", DRdata, 32'h55AA55AA);
        DReq = 1'b0; MemAck = 1'b0;
        repeat (2) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
